// File: rtl/cpu_pkg.sv
// Shared widths and FSM encoding for the CPU memory block.
package cpu_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PROG = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/ram16x8.sv
// Word store: one synchronous write port, one combinational read port, no reset.
module ram16x8
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/memory_unit.sv
// CPU RAM with MAR, bus interface and a streaming program loader.
module memory_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              lm,
    input  logic              ro,
    input  logic              ri,
    input  logic              prog_en,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_valid,
    output logic              prog_ready,
    output logic              prog_done,
    output logic [ADDR_W-1:0] mar,
    output logic              err
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] load_cnt;
    logic              run, accept, we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata, rdata;

    // Reset masks every control input in its own cycle, including writes.
    assign run    = (state == RUN) && !rst;
    assign accept = (state == PROG) && prog_valid && !rst;

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (prog_en) state_nxt = PROG;
            PROG: begin
                if (!prog_en)                 state_nxt = RUN;
                else if (accept && &load_cnt) state_nxt = DONE;
            end
            DONE:    if (!prog_en) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Loader and CPU never both write: they are active in disjoint states.
    always_comb begin
        we    = 1'b0;
        waddr = mar;
        wdata = bus_in;
        if (accept) begin
            we    = 1'b1;
            waddr = load_cnt;
            wdata = prog_data;
        end else if (run && ri && !ro) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mar      <= '0;
            load_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (run && lm)      mar <= bus_in[ADDR_W-1:0];
            if (run && ro && ri) err <= 1'b1;
            // Holding the count at 0 throughout RUN makes every PROG entry start at 0.
            if (state == RUN)   load_cnt <= '0;
            else if (accept)    load_cnt <= load_cnt + ADDR_W'(1);
        end
    end

    ram16x8 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (mar),
        .rdata (rdata)
    );

    assign bus_oe     = run && ro;
    assign bus_out    = bus_oe ? rdata : '0;
    assign prog_ready = (state == PROG) && !rst;
    assign prog_done  = (state == DONE) && !rst;
endmodule

// File: tb/tb_memory_unit.sv
// Bench for memory_unit: vector table, directed loader sequences, random vs. model.
module tb_memory_unit;
    logic       clk = 1'b0;
    logic       rst, lm, ro, ri, prog_en, prog_valid;
    logic [7:0] bus_in, prog_data, bus_out;
    logic       bus_oe, prog_ready, prog_done, err;
    logic [3:0] mar;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] m [16];
    int mst, mmar, mcnt;
    logic merr;

    memory_unit #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .lm(lm), .ro(ro), .ri(ri), .prog_en(prog_en), .prog_data(prog_data),
        .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_done(prog_done),
        .mar(mar), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected < 500000", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst, lm, ro, ri, pe, pv;
        logic [7:0] bus;
        logic       oe;
        logic [7:0] out;
        logic [3:0] mar;
        logic       rdy, done, err;
    } vec_t;

    function automatic vec_t v(input logic r, input logic l, input logic o, input logic i,
                               input logic pe, input logic pv, input logic [7:0] bus,
                               input logic eoe, input logic [7:0] eout, input logic [3:0] emar,
                               input logic erdy, input logic edone, input logic eerr);
        vec_t x;
        x.rst = r; x.lm = l; x.ro = o; x.ri = i; x.pe = pe; x.pv = pv; x.bus = bus;
        x.oe = eoe; x.out = eout; x.mar = emar; x.rdy = erdy; x.done = edone; x.err = eerr;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; lm = 0; ro = 0; ri = 0; prog_en = 0; prog_valid = 0;
        bus_in = 8'h00; prog_data = 8'h00;
    endtask

    // Two cycles: load MAR, then drive RAM onto the bus and compare with the bench copy.
    task automatic read_chk(input int a, input string nm);
        idle(); lm = 1; bus_in = 8'(a);
        tick();
        idle(); ro = 1;
        @(negedge clk);
        chk($sformatf("%s.mar%0d", nm, a), 32'(mar), 32'(a));
        chk($sformatf("%s.oe%0d", nm, a), 32'(bus_oe), 32'd1);
        chk($sformatf("%s.data%0d", nm, a), 32'(bus_out), 32'(m[a]));
        tick();
        idle();
    endtask

    vec_t vt [26];

    initial begin
        int acc, c;
        logic fin, eoe;
        logic [7:0] eout;

        vt[0]  = v(0,0,0,0,0,0,8'h00, 0,8'h00,4'd0,0,0,0);
        vt[1]  = v(0,1,0,0,0,0,8'h05, 0,8'h00,4'd0,0,0,0);
        vt[2]  = v(0,0,0,1,0,0,8'hA7, 0,8'h00,4'd5,0,0,0);
        vt[3]  = v(0,0,1,0,0,0,8'h00, 1,8'hA7,4'd5,0,0,0);
        vt[4]  = v(0,1,0,0,0,0,8'h06, 0,8'h00,4'd5,0,0,0);
        vt[5]  = v(0,0,0,1,0,0,8'h66, 0,8'h00,4'd6,0,0,0);
        vt[6]  = v(0,1,0,0,0,0,8'h01, 0,8'h00,4'd6,0,0,0);
        vt[7]  = v(0,1,0,1,0,0,8'h06, 0,8'h00,4'd1,0,0,0);
        vt[8]  = v(0,0,1,0,0,0,8'h00, 1,8'h66,4'd6,0,0,0);
        vt[9]  = v(0,1,0,0,0,0,8'h01, 0,8'h00,4'd6,0,0,0);
        vt[10] = v(0,0,1,0,0,0,8'h00, 1,8'h06,4'd1,0,0,0);
        vt[11] = v(0,1,0,0,0,0,8'h02, 0,8'h00,4'd1,0,0,0);
        vt[12] = v(0,0,0,1,0,0,8'h44, 0,8'h00,4'd2,0,0,0);
        vt[13] = v(0,0,1,1,0,0,8'h99, 1,8'h44,4'd2,0,0,0);
        vt[14] = v(0,0,1,0,0,0,8'h00, 1,8'h44,4'd2,0,0,1);
        vt[15] = v(0,0,0,0,0,0,8'h00, 0,8'h00,4'd2,0,0,1);
        vt[16] = v(0,1,1,0,0,0,8'h05, 1,8'h44,4'd2,0,0,1);
        vt[17] = v(0,0,1,0,0,0,8'h00, 1,8'hA7,4'd5,0,0,1);
        vt[18] = v(0,0,0,0,1,0,8'h00, 0,8'h00,4'd5,0,0,1);
        vt[19] = v(0,0,1,0,1,0,8'h00, 0,8'h00,4'd5,1,0,1);
        vt[20] = v(0,0,0,0,0,0,8'h00, 0,8'h00,4'd5,1,0,1);
        vt[21] = v(0,0,1,0,0,0,8'h00, 1,8'hA7,4'd5,0,0,1);
        vt[22] = v(1,0,0,0,0,0,8'h00, 0,8'h00,4'd5,0,0,1);
        vt[23] = v(0,0,0,0,0,0,8'h00, 0,8'h00,4'd0,0,0,0);
        vt[24] = v(0,1,0,0,0,0,8'h05, 0,8'h00,4'd0,0,0,0);
        vt[25] = v(0,0,1,0,0,0,8'h00, 1,8'hA7,4'd5,0,0,0);

        idle(); rst = 1;
        tick(); tick();
        idle();

        for (int i = 0; i < 26; i++) begin
            rst = vt[i].rst; lm = vt[i].lm; ro = vt[i].ro; ri = vt[i].ri;
            prog_en = vt[i].pe; prog_valid = vt[i].pv; bus_in = vt[i].bus; prog_data = 8'h00;
            @(negedge clk);
            chk($sformatf("vec%0d.oe", i),   32'(bus_oe),     32'(vt[i].oe));
            chk($sformatf("vec%0d.out", i),  32'(bus_out),    32'(vt[i].out));
            chk($sformatf("vec%0d.mar", i),  32'(mar),        32'(vt[i].mar));
            chk($sformatf("vec%0d.rdy", i),  32'(prog_ready), 32'(vt[i].rdy));
            chk($sformatf("vec%0d.done", i), 32'(prog_done),  32'(vt[i].done));
            chk($sformatf("vec%0d.err", i),  32'(err),        32'(vt[i].err));
            tick();
        end

        // Full program load with valid held high.
        idle(); prog_en = 1;
        @(negedge clk);
        chk("load.rdy_in_run", 32'(prog_ready), 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            prog_valid = 1; prog_data = 8'(8'h10 + i);
            @(negedge clk);
            chk($sformatf("load.rdy%0d", i), 32'(prog_ready), 32'd1);
            chk($sformatf("load.done%0d", i), 32'(prog_done), 32'd0);
            tick();
            m[i] = 8'(8'h10 + i);
        end
        prog_valid = 0; ro = 1;
        @(negedge clk);
        chk("load.done", 32'(prog_done), 32'd1);
        chk("load.rdy_after", 32'(prog_ready), 32'd0);
        chk("load.oe_ignored", 32'(bus_oe), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("load.done_hold", 32'(prog_done), 32'd1);
        tick();
        read_chk(3, "load.read");

        // Backpressure: valid on every other cycle, junk data on the idle ones.
        idle(); prog_en = 1;
        tick();
        acc = 0; c = 0;
        while (acc < 16 && c < 64) begin
            prog_valid = (c % 2 == 0);
            prog_data  = prog_valid ? 8'(8'h20 + acc) : 8'hEE;
            @(negedge clk);
            chk($sformatf("bp.rdy%0d", c), 32'(prog_ready), 32'd1);
            chk($sformatf("bp.done%0d", c), 32'(prog_done), 32'd0);
            tick();
            if (prog_valid) begin
                m[acc] = prog_data;
                acc++;
            end
            c++;
        end
        chk("bp.cycles", 32'(c), 32'd31);
        prog_valid = 0;
        @(negedge clk);
        chk("bp.done", 32'(prog_done), 32'd1);
        tick();
        idle();
        tick();
        for (int a = 0; a < 16; a += 5) read_chk(a, "bp.read");
        read_chk(15, "bp.read");

        // Reset arrives after five accepted words, with a sixth word offered.
        idle(); prog_en = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            prog_valid = 1; prog_data = 8'(8'h30 + i);
            tick();
            m[i] = 8'(8'h30 + i);
        end
        rst = 1; prog_data = 8'hEE;
        @(negedge clk);
        chk("rst.rdy_in_rst", 32'(prog_ready), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("rst.rdy", 32'(prog_ready), 32'd0);
        chk("rst.done", 32'(prog_done), 32'd0);
        chk("rst.mar", 32'(mar), 32'd0);
        chk("rst.oe", 32'(bus_oe), 32'd0);
        chk("rst.out", 32'(bus_out), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        tick();
        for (int a = 0; a < 6; a++) read_chk(a, "rst.read");

        // Randomized traffic against the behavioural model.
        idle(); rst = 1;
        tick();
        idle();
        mst = 0; mmar = 0; mcnt = 0; merr = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            lm  = 1'($urandom_range(0, 1));
            ro  = ($urandom_range(0, 3) == 0);
            ri  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) prog_en = !prog_en;
            prog_valid = 1'($urandom_range(0, 1));
            bus_in = 8'($urandom);
            prog_data = 8'($urandom);

            eoe  = !rst && mst == 0 && ro;
            eout = eoe ? m[mmar] : 8'h00;
            @(negedge clk);
            chk($sformatf("rnd%0d.oe", n),   32'(bus_oe),     32'(eoe));
            chk($sformatf("rnd%0d.out", n),  32'(bus_out),    32'(eout));
            chk($sformatf("rnd%0d.mar", n),  32'(mar),        32'(mmar));
            chk($sformatf("rnd%0d.rdy", n),  32'(prog_ready), 32'(!rst && mst == 1));
            chk($sformatf("rnd%0d.done", n), 32'(prog_done),  32'(!rst && mst == 2));
            chk($sformatf("rnd%0d.err", n),  32'(err),        32'(merr));

            if (rst) begin
                mst = 0; mmar = 0; mcnt = 0; merr = 0;
            end else begin
                case (mst)
                    0: begin
                        if (ro && ri) merr = 1;
                        else if (ri) m[mmar] = bus_in;
                        if (lm) mmar = int'(bus_in[3:0]);
                        if (prog_en) begin mst = 1; mcnt = 0; end
                    end
                    1: begin
                        fin = 0;
                        if (prog_valid) begin
                            m[mcnt] = prog_data;
                            fin = (mcnt == 15);
                            mcnt = (mcnt + 1) % 16;
                        end
                        if (!prog_en) mst = 0;
                        else if (fin) mst = 2;
                    end
                    default: if (!prog_en) mst = 0;
                endcase
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_unit.md
MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 The module SHALL expose parameter DATA_W, default 8, bus and word width.
REQ-002 The module SHALL expose parameter ADDR_W, default 4, memory address width (2^ADDR_W = 16 words).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 bus_in  input  DATA_W  current value of the shared CPU bus.
REQ-006 bus_out  output  DATA_W  word presented to the bus.
REQ-007 bus_oe  output  1  high when this block drives the bus.
REQ-008 lm  input  1  control: load MAR from bus_in[ADDR_W-1:0].
REQ-009 ro  input  1  control: RAM out, drive mem[MAR] onto the bus.
REQ-010 ri  input  1  control: RAM in, write bus_in to mem[MAR].
REQ-011 prog_en  input  1  request program-load mode.
REQ-012 prog_data  input  DATA_W  word to load.
REQ-013 prog_valid  input  1  prog_data is valid.
REQ-014 prog_ready  output  1  loader accepts a word this cycle.
REQ-015 prog_done  output  1  all 16 words loaded.
REQ-016 mar  output  ADDR_W  current MAR value, for debug.
REQ-017 err  output  1  sticky flag: ro and ri were asserted together.

Function
REQ-018 The FSM SHALL have the states RUN, PROG and DONE.
- RUN->PROG when prog_en=1.
- PROG->DONE on the accepted word at load address 15.
- PROG->RUN when prog_en=0 (abort; words already written are kept).
- DONE->RUN when prog_en=0.
REQ-019 In RUN, lm=1 SHALL load MAR from bus_in[ADDR_W-1:0] at the clock edge.
REQ-020 In RUN, ro=1 SHALL set bus_oe=1 and bus_out=mem[MAR] combinationally, in the same cycle (zero latency).
REQ-021 In RUN, ri=1 and ro=0 SHALL write bus_in to mem[MAR] at the clock edge; a read in the next cycle SHALL return the new word.
REQ-022 When lm and ri are both asserted, the write SHALL use the pre-edge MAR and MAR SHALL update at the same edge.
REQ-023 When lm and ro are both asserted, the bus SHALL carry mem[old MAR] for that cycle.
REQ-024 When ro and ri are both asserted, ro SHALL win: no write, bus driven, and err set to 1 until reset.
REQ-025 When bus_oe=0, bus_out SHALL be 0.
REQ-026 In PROG and DONE, lm, ro and ri SHALL be ignored, and bus_oe SHALL be 0.
REQ-027 prog_ready SHALL be 1 only in PROG.
- A word is accepted on a cycle with prog_valid=1 and prog_ready=1.
- The accepted word is written to mem[load_cnt], and load_cnt increments.
REQ-028 load_cnt SHALL be 0 on entry to PROG; it SHALL wrap 15->0 on entry to DONE.
REQ-029 prog_done SHALL be 1 only in DONE.
REQ-030 If prog_valid=0, or the cycle is not in PROG, no load write SHALL occur.

Reset
REQ-031 While rst=1 at a clock edge, the block SHALL set: state=RUN, MAR=0, load_cnt=0, err=0.
REQ-032 Reset SHALL leave these outputs at: bus_oe=0, bus_out=0, prog_ready=0, prog_done=0, mar=0.
REQ-033 Memory contents SHALL NOT be cleared by reset; a reset during PROG aborts the load and keeps the words already written.
REQ-034 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-035 The shared package cpu_pkg SHALL hold DATA_W, ADDR_W and the state typedef (RUN/PROG/DONE).
REQ-036 Storage SHALL be a sub-module ram16x8: one synchronous write port and one combinational read port.
REQ-037 The FSM, MAR and write-port mux SHALL live in memory_unit.

Verification
REQ-038 Run-mode write/read: lm with bus=0x05; then ri with bus=0xA7; then ro -> bus_oe=1, bus_out=0xA7, mar=5.
REQ-039 Program load: prog_en=1, then 16 valid words 0x10..0x1F with prog_valid held high -> prog_ready high 16 cycles, then prog_done=1; afterwards in RUN, lm=0x3 then ro -> 0x13.
REQ-040 Backpressure: in PROG, toggle prog_valid every other cycle -> only valid cycles write, load_cnt advances only on those cycles, and DONE is still reached after exactly 16 accepts.
REQ-041 Conflict: ro=ri=1 with MAR=2 holding 0x44 and bus_in=0x99 -> mem[2] stays 0x44, bus_out=0x44, err=1 and stays 1 until rst.
REQ-042 Simultaneous lm+ri: MAR=1, bus_in=0x06 with lm=ri=1 -> mem[1]=0x06, mem[6] unchanged, mar=6.
REQ-043 Reset mid-load: assert rst after 5 accepted words -> state RUN, prog_ready=0, mar=0; mem[0..4] keep the loaded words.
